// File: rtl/lsu_pkg.sv
// Shared definitions for the multi-cycle load/store unit: access sizes,
// completion error codes, FSM encoding and the alignment rule.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_MIS  = 2'd1;
  localparam logic [1:0] ERR_BUS  = 2'd2;
  localparam logic [1:0] ERR_ILL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] low);
    logic m;
    case (size)
      SZ_H:    m = low[0];
      SZ_W:    m = (low[1:0] != 2'b00);
      SZ_D:    m = (low != 3'b000);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/data placement and load extract/extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int BYTES  = XLEN / 8,
  parameter int LANE_W = $clog2(XLEN / 8)
) (
  input  logic [LANE_W-1:0] lane,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [BYTES-1:0]  wmask,
  output logic [XLEN-1:0]   wdata_sh,
  output logic [XLEN-1:0]   ldata
);

  logic [LANE_W+2:0] shamt;
  logic [BYTES-1:0]  ones;
  logic [XLEN-1:0]   sized;
  logic [XLEN-1:0]   rsh;

  assign shamt = {lane, 3'b000};
  assign rsh   = rdata >> shamt;

  always_comb begin
    ones  = '0;
    sized = '0;
    ldata = '0;
    case (size)
      SZ_B: begin
        ones  = BYTES'(1'b1);
        sized = XLEN'(wdata[7:0]);
        if (uns) ldata = XLEN'(rsh[7:0]);
        else     ldata = XLEN'($signed(rsh[7:0]));
      end
      SZ_H: begin
        ones  = BYTES'(2'b11);
        sized = XLEN'(wdata[15:0]);
        if (uns) ldata = XLEN'(rsh[15:0]);
        else     ldata = XLEN'($signed(rsh[15:0]));
      end
      SZ_W: begin
        ones  = BYTES'(4'hF);
        sized = XLEN'(wdata[31:0]);
        if (uns) ldata = XLEN'(rsh[31:0]);
        else     ldata = XLEN'($signed(rsh[31:0]));
      end
      default: begin
        ones  = '1;
        sized = wdata;
        ldata = rsh;
      end
    endcase
    wmask    = ones << lane;
    wdata_sh = sized << shamt;
  end

endmodule

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: one access at a time over a req/rsp memory port,
// with misalign/illegal trapping and a bounded wait for the bus.
module lsu_mc
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_store,
  input  logic [2:0]          in_funct3,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic [4:0]          in_rd,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [XLEN/8-1:0]   mem_req_wmask,
  output logic [XLEN-1:0]     mem_req_wdata,
  input  logic                mem_rsp_valid,
  input  logic [XLEN-1:0]     mem_rsp_rdata,
  output logic                wb_valid,
  output logic                wb_wen,
  output logic [4:0]          wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic [1:0]          wb_err
);

  localparam int BYTES  = XLEN / 8;
  localparam int LANE_W = $clog2(BYTES);

  state_e              state_r, state_nxt;
  logic                store_r;
  logic [2:0]          f3_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [XLEN-1:0]     wdata_r;
  logic [4:0]          rd_r;
  logic [1:0]          err_r;
  logic [XLEN-1:0]     ldata_r;
  logic                discard_r;
  logic [15:0]         cnt_r;

  logic                accept_s, hs_s, rsp_take_s, to_s, illegal_s;
  logic [1:0]          err_in_s;
  logic [BYTES-1:0]    wmask_s;
  logic [XLEN-1:0]     wdata_sh_s, ldata_s;

  assign accept_s   = in_valid && (state_r == ST_IDLE);
  assign hs_s       = (state_r == ST_REQ) && mem_req_ready;
  assign rsp_take_s = (state_r == ST_WAIT) && mem_rsp_valid && !discard_r;
  assign to_s       = (TIMEOUT != 0) && (cnt_r == 16'(TIMEOUT - 1));

  // Unsigned stores, the nonexistent "LDU", and 64-bit forms on a 32-bit core are illegal.
  assign illegal_s = (in_store && in_funct3[2]) || (in_funct3 == F3_BAD) ||
                     ((XLEN == 32) && ((in_funct3[1:0] == SZ_D) || (in_funct3 == F3_LWU)));
  assign err_in_s  = illegal_s ? ERR_ILL :
                     misaligned(in_funct3[1:0], in_addr[2:0]) ? ERR_MIS : ERR_NONE;

  lsu_align #(.XLEN(XLEN)) u_align (
    .lane     (addr_r[LANE_W-1:0]),
    .size     (f3_r[1:0]),
    .uns      (f3_r[2]),
    .wdata    (wdata_r),
    .rdata    (mem_rsp_rdata),
    .wmask    (wmask_s),
    .wdata_sh (wdata_sh_s),
    .ldata    (ldata_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt;
  end

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: if (accept_s) state_nxt = (err_in_s == ERR_NONE) ? ST_REQ : ST_DONE;
               else          state_nxt = ST_IDLE;
      ST_REQ:  if (hs_s)      state_nxt = ST_WAIT;
               else if (to_s) state_nxt = ST_DONE;
               else           state_nxt = ST_REQ;
      ST_WAIT: if (rsp_take_s || to_s) state_nxt = ST_DONE;
               else                    state_nxt = ST_WAIT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Access context, captured load result, wait counter and stale-response tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_r   <= 1'b0;
      f3_r      <= 3'd0;
      addr_r    <= '0;
      wdata_r   <= '0;
      rd_r      <= 5'd0;
      err_r     <= ERR_NONE;
      ldata_r   <= '0;
      discard_r <= 1'b0;
      cnt_r     <= 16'd0;
    end else begin
      if (accept_s) begin
        store_r <= in_store;
        f3_r    <= in_funct3;
        addr_r  <= in_addr;
        wdata_r <= in_wdata;
        rd_r    <= in_rd;
        err_r   <= err_in_s;
        ldata_r <= '0;
      end else if (rsp_take_s) begin
        ldata_r <= ldata_s;
      end else if ((state_r == ST_REQ && !hs_s && to_s) || (state_r == ST_WAIT && to_s)) begin
        err_r   <= ERR_BUS;
      end
      if (accept_s || hs_s)                                 cnt_r <= 16'd0;
      else if (state_r == ST_REQ || state_r == ST_WAIT)     cnt_r <= cnt_r + 16'd1;
      if (mem_rsp_valid && discard_r)                       discard_r <= 1'b0;
      else if (state_r == ST_WAIT && to_s && !rsp_take_s)   discard_r <= 1'b1;
    end
  end

  assign in_ready      = (state_r == ST_IDLE);
  assign mem_req_valid = (state_r == ST_REQ);
  assign mem_req_addr  = mem_req_valid ? {addr_r[ADDR_W-1:LANE_W], {LANE_W{1'b0}}} : '0;
  assign mem_req_wen   = mem_req_valid && store_r;
  assign mem_req_wmask = mem_req_wen ? wmask_s : '0;
  assign mem_req_wdata = mem_req_wen ? wdata_sh_s : '0;
  assign wb_valid      = (state_r == ST_DONE);
  assign wb_wen        = wb_valid && !store_r && (err_r == ERR_NONE) && (rd_r != 5'd0);
  assign wb_rd         = wb_valid ? rd_r : 5'd0;
  assign wb_data       = (wb_valid && !store_r && (err_r == ERR_NONE)) ? ldata_r : '0;
  assign wb_err        = wb_valid ? err_r : ERR_NONE;

endmodule
